// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared sequencer state, forwarding encodings and datapath constants.
package cpu_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_e;

    localparam int          REG_W     = 4;
    localparam logic [1:0]  FWD_REG   = 2'b00;
    localparam logic [1:0]  FWD_WB    = 2'b01;
    localparam logic [1:0]  FWD_EXMEM = 2'b10;
    localparam logic [15:0] NOP       = 16'h0000;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: operand forwarding compare for one ALU input; EX/MEM beats WB, R0 never forwarded.
module fwd_select
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_regwrite_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_regwrite_i,
    output logic [1:0]       sel_o
);
    logic mem_hit, wb_hit;

    assign mem_hit = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
    assign wb_hit  = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src_i);
    assign sel_o   = mem_hit ? FWD_EXMEM : wb_hit ? FWD_WB : FWD_REG;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use/branch/stall control and HLT drain for the 5-stage CPU.
// Define PIPE_HAZARD_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_hlt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             halted,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [15:0]      perf_stall_cnt,
    output logic [15:0]      perf_flush_cnt,
`endif
    output logic             mem_timeout
);
    state_e     state_q, state_d;
    logic [7:0] drain_q, drain_d, wait_q, wait_d;
    logic       timeout_q, stall, load_use;

    fwd_select u_fwd_a (
        .src_i(ex_rs), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .sel_o(ForwardA)
    );
    fwd_select u_fwd_b (
        .src_i(ex_rt), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .sel_o(ForwardB)
    );

    assign stall    = imem_stall || dmem_stall;
    assign load_use = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign wait_d   = !stall ? 8'd0 : (wait_q == 8'(TIMEOUT)) ? wait_q : wait_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        unique case (state_q)
            RUN: begin
                if (stall) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    pipe_freeze = dmem_stall;
                end else if (ex_br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_hlt) begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    state_d = DRAIN;
                    drain_d = 8'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                ifid_flush  = 1'b1;
                pipe_freeze = dmem_stall;
                // Only advance the drain while the back end is actually moving.
                if (!dmem_stall) begin
                    drain_d = (drain_q == 8'd0) ? 8'd0 : drain_q - 8'd1;
                    state_d = (drain_q <= 8'd1) ? HALTED : DRAIN;
                end
            end
            HALTED: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                pipe_freeze = 1'b1;
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            drain_q   <= 8'd0;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_q || (wait_d == 8'(TIMEOUT));
        end
    end

    assign halted      = (state_q == HALTED);
    assign mem_timeout = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (state_q == RUN && !pc_we && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (state_q == RUN && ifid_flush && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, id_hlt, ex_memread, ex_br_taken, mem_regwrite, wb_regwrite;
    logic       imem_stall, dmem_stall;
    logic [1:0] ForwardA, ForwardB;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, halted, mem_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_hlt(id_hlt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .halted(halted),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .mem_timeout(mem_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rt, id_hlt, ex_memread, ex_br_taken, mem_regwrite, wb_regwrite} = '0;
        {imem_stall, dmem_stall} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        imem_stall = 1'b1;
        dmem_stall = 1'b1;
        ex_br_taken = 1'b1;
        tick();
        tick();
        checks++; if ({pc_we, ifid_we} !== 2'b11) begin errs++; $display("FAIL rst_we: got %b exp 11", {pc_we, ifid_we}); end
        checks++; if ({ifid_flush, idex_bubble, pipe_freeze} !== 3'b000) begin errs++; $display("FAIL rst_ctl: got %b exp 000", {ifid_flush, idex_bubble, pipe_freeze}); end
        rst = 1'b0;
        idle();
        #1;
        checks++; if ({halted, mem_timeout} !== 2'b00) begin errs++; $display("FAIL rst_state: got %b exp 00", {halted, mem_timeout}); end
        checks++; if ({pc_we, ifid_we, ForwardA, ForwardB} !== 6'b110000) begin errs++; $display("FAIL rst_run: got %b exp 110000", {pc_we, ifid_we, ForwardA, ForwardB}); end
    endtask

    task automatic test_forwarding();
        idle();
        mem_rd = 4'd1; mem_regwrite = 1'b1; wb_rd = 4'd1; wb_regwrite = 1'b1; ex_rs = 4'd1;
        #1;
        checks++; if (ForwardA !== 2'b10) begin errs++; $display("FAIL fwd_exmem: got %b exp 10", ForwardA); end
        mem_regwrite = 1'b0;
        #1;
        checks++; if (ForwardA !== 2'b01) begin errs++; $display("FAIL fwd_wb: got %b exp 01", ForwardA); end
        mem_regwrite = 1'b1; mem_rd = 4'd0; wb_rd = 4'd0; ex_rs = 4'd0;
        #1;
        checks++; if (ForwardA !== 2'b00) begin errs++; $display("FAIL fwd_r0: got %b exp 00", ForwardA); end
        ex_rt = 4'd5; wb_rd = 4'd5; mem_rd = 4'd6;
        #1;
        checks++; if (ForwardB !== 2'b01) begin errs++; $display("FAIL fwdb_wb: got %b exp 01", ForwardB); end
        mem_rd = 4'd5;
        #1;
        checks++; if ({ForwardA, ForwardB} !== 4'b0010) begin errs++; $display("FAIL fwdb_exmem: got %b exp 0010", {ForwardA, ForwardB}); end
        wb_regwrite = 1'b0; mem_regwrite = 1'b0;
        #1;
        checks++; if (ForwardB !== 2'b00) begin errs++; $display("FAIL fwdb_nowrite: got %b exp 00", ForwardB); end
    endtask

    task automatic test_load_use();
        idle();
        ex_memread = 1'b1; ex_rd = 4'd2; id_rs = 4'd3; id_rt = 4'd2; id_uses_rt = 1'b1;
        #1;
        checks++; if ({pc_we, ifid_we, idex_bubble, ifid_flush} !== 4'b0010) begin errs++; $display("FAIL lu_stall: got %b exp 0010", {pc_we, ifid_we, idex_bubble, ifid_flush}); end
        tick();
        ex_memread = 1'b0; ex_rd = 4'd0;
        #1;
        checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b110) begin errs++; $display("FAIL lu_resume: got %b exp 110", {pc_we, ifid_we, idex_bubble}); end
        ex_memread = 1'b1; ex_rd = 4'd2; id_uses_rt = 1'b0;
        #1;
        checks++; if ({pc_we, idex_bubble} !== 2'b10) begin errs++; $display("FAIL lu_no_rt: got %b exp 10", {pc_we, idex_bubble}); end
        id_rs = 4'd2;
        #1;
        checks++; if ({pc_we, idex_bubble} !== 2'b01) begin errs++; $display("FAIL lu_rs: got %b exp 01", {pc_we, idex_bubble}); end
        ex_rd = 4'd0; id_rs = 4'd0;
        #1;
        checks++; if ({pc_we, idex_bubble} !== 2'b10) begin errs++; $display("FAIL lu_r0: got %b exp 10", {pc_we, idex_bubble}); end
        tick();
    endtask

    task automatic test_branch();
        idle();
        ex_memread = 1'b1; ex_rd = 4'd2; id_rs = 4'd2; ex_br_taken = 1'b1;
        #1;
        checks++; if ({ifid_flush, idex_bubble, pc_we} !== 3'b111) begin errs++; $display("FAIL br_over_lu: got %b exp 111", {ifid_flush, idex_bubble, pc_we}); end
        dmem_stall = 1'b1;
        #1;
        checks++; if ({ifid_flush, idex_bubble, pc_we, ifid_we, pipe_freeze} !== 5'b00001) begin errs++; $display("FAIL stall_over_br: got %b exp 00001", {ifid_flush, idex_bubble, pc_we, ifid_we, pipe_freeze}); end
        idle();
        imem_stall = 1'b1;
        #1;
        checks++; if ({pc_we, ifid_we, pipe_freeze} !== 3'b000) begin errs++; $display("FAIL imem_stall: got %b exp 000", {pc_we, ifid_we, pipe_freeze}); end
        idle();
        ex_br_taken = 1'b1; id_hlt = 1'b1;
        tick();
        idle();
        #1;
        checks++; if ({pc_we, ifid_flush, halted} !== 3'b100) begin errs++; $display("FAIL br_drops_hlt: got %b exp 100", {pc_we, ifid_flush, halted}); end
    endtask

    task automatic test_halt_drain();
        do_reset();
        id_hlt = 1'b1;
        #1;
        checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b000) begin errs++; $display("FAIL hlt_id: got %b exp 000", {pc_we, ifid_we, idex_bubble}); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            id_hlt = 1'b0;
            #1;
            checks++; if (halted !== (i == 4)) begin errs++; $display("FAIL drain_halt[%0d]: got %b exp %b", i, halted, (i == 4)); end
            if (i == 1) begin
                checks++; if ({pc_we, ifid_we, ifid_flush} !== 3'b001) begin errs++; $display("FAIL drain_ctl: got %b exp 001", {pc_we, ifid_we, ifid_flush}); end
            end
        end
        checks++; if ({pc_we, ifid_we, pipe_freeze} !== 3'b001) begin errs++; $display("FAIL halted_ctl: got %b exp 001", {pc_we, ifid_we, pipe_freeze}); end
        ex_br_taken = 1'b1;
        tick();
        tick();
        checks++; if (halted !== 1'b1) begin errs++; $display("FAIL halted_sticky: got %b exp 1", halted); end
    endtask

    task automatic test_reset_in_halted();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({halted, pc_we, ifid_we, pipe_freeze} !== 4'b0110) begin errs++; $display("FAIL rst_halted: got %b exp 0110", {halted, pc_we, ifid_we, pipe_freeze}); end
    endtask

    task automatic test_drain_stall();
        do_reset();
        id_hlt = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            id_hlt = 1'b0;
            dmem_stall = (i == 2 || i == 3);
            #1;
            checks++; if (halted !== (i == 6)) begin errs++; $display("FAIL drain_stall_halt[%0d]: got %b exp %b", i, halted, (i == 6)); end
            if (i == 2) begin
                checks++; if (pipe_freeze !== 1'b1) begin errs++; $display("FAIL drain_freeze: got %b exp 1", pipe_freeze); end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_stall = 1'b1;
        for (int i = 1; i <= 254; i++) tick();
        checks++; if (mem_timeout !== 1'b0) begin errs++; $display("FAIL timeout_early: got %b exp 0", mem_timeout); end
        checks++; if ({pc_we, pipe_freeze} !== 2'b01) begin errs++; $display("FAIL timeout_freeze: got %b exp 01", {pc_we, pipe_freeze}); end
        tick();
        checks++; if (mem_timeout !== 1'b1) begin errs++; $display("FAIL timeout_set: got %b exp 1", mem_timeout); end
        dmem_stall = 1'b0;
        tick();
        tick();
        tick();
        checks++; if ({mem_timeout, pc_we} !== 2'b11) begin errs++; $display("FAIL timeout_sticky: got %b exp 11", {mem_timeout, pc_we}); end
        do_reset();
        checks++; if (mem_timeout !== 1'b0) begin errs++; $display("FAIL timeout_clear: got %b exp 0", mem_timeout); end
        dmem_stall = 1'b1;
        for (int i = 1; i <= 200; i++) tick();
        dmem_stall = 1'b0;
        tick();
        dmem_stall = 1'b1;
        for (int i = 1; i <= 100; i++) tick();
        checks++; if (mem_timeout !== 1'b0) begin errs++; $display("FAIL timeout_gap_clears: got %b exp 0", mem_timeout); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_halt_drain();
        test_reset_in_halted();
        test_drain_stall();
        test_reset_in_halted();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
